// File: rtl/gppcu_instr_dispatcher.sv
// Streams a contiguous instruction block from sync-read memory into the core.
// A 2-entry buffer hides the read latency and core back-pressure.
module gppcu_instr_dispatcher #(
   parameter int DBW  = 32,
   parameter int IABW = 10,
   parameter int CBW  = 11
) (
   input  logic            iACLK,
   input  logic            inRST,
   input  logic            iSTART,
   input  logic [IABW-1:0] iBASE_ADDR,
   input  logic [CBW-1:0]  iINSTR_COUNT,
   input  logic            iABORT,
   output logic            oBUSY,
   output logic            oDONE,
   output logic            oABORTED,
   output logic [IABW-1:0] oIMEM_ADDR,
   output logic            oIMEM_RD,
   input  logic [DBW-1:0]  iIMEM_RDATA,
   output logic [DBW-1:0]  oINSTR,
   output logic            oINSTR_VALID,
   input  logic            iINSTR_READY,
   input  logic            iCORE_IDLING,
   output logic [CBW-1:0]  oISSUED_CNT
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FIN
   } state_t;

   state_t         state;
   logic [CBW-1:0] count;
   logic [CBW-1:0] reads_left;
   logic [CBW-1:0] issued_inc;
   logic [DBW-1:0] slot0;
   logic [DBW-1:0] slot1;
   logic [1:0]     occ;
   logic [1:0]     fill;
   logic           rd_pend;
   logic           drain_first;
   logic           pop;
   logic           push;
   logic           rd;

   assign oBUSY        = (state != IDLE);
   assign oINSTR       = slot0;
   assign oINSTR_VALID = (state == RUN) && (occ != 2'd0);
   assign oIMEM_RD     = rd;

   assign pop        = oINSTR_VALID && iINSTR_READY;
   assign push       = (state == RUN) && rd_pend && !iABORT;
   assign issued_inc = oISSUED_CNT + 1'b1;

   // Slots committed after this edge; a pop frees one in time for a new read.
   assign fill = occ + {1'b0, rd_pend} - {1'b0, pop};
   assign rd   = (state == RUN) && (reads_left != '0) && (fill < 2'd2);

   always_ff @(posedge iACLK or negedge inRST) begin
      if (!inRST) begin
         state       <= IDLE;
         count       <= '0;
         reads_left  <= '0;
         oIMEM_ADDR  <= '0;
         oISSUED_CNT <= '0;
         oABORTED    <= 1'b0;
         oDONE       <= 1'b0;
         slot0       <= '0;
         slot1       <= '0;
         occ         <= 2'd0;
         rd_pend     <= 1'b0;
         drain_first <= 1'b0;
      end else begin
         oDONE   <= 1'b0;
         rd_pend <= rd;
         if (rd) begin
            oIMEM_ADDR <= oIMEM_ADDR + 1'b1;
            reads_left <= reads_left - 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (iSTART && !iABORT) begin
                  oIMEM_ADDR  <= iBASE_ADDR;
                  count       <= iINSTR_COUNT;
                  reads_left  <= iINSTR_COUNT;
                  oISSUED_CNT <= '0;
                  oABORTED    <= 1'b0;
                  occ         <= 2'd0;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (pop) oISSUED_CNT <= issued_inc;
               if (iABORT) begin
                  occ         <= 2'd0;
                  oABORTED    <= 1'b1;
                  drain_first <= 1'b1;
                  state       <= DRAIN;
               end else begin
                  case ({push, pop})
                     2'b10: begin
                        if (occ == 2'd0) slot0 <= iIMEM_RDATA;
                        else slot1 <= iIMEM_RDATA;
                        occ <= occ + 2'd1;
                     end
                     2'b01: begin
                        slot0 <= slot1;
                        occ   <= occ - 2'd1;
                     end
                     2'b11: begin
                        if (occ == 2'd1) begin
                           slot0 <= iIMEM_RDATA;
                        end else begin
                           slot0 <= slot1;
                           slot1 <= iIMEM_RDATA;
                        end
                     end
                     default: ;
                  endcase
                  if ((count == '0) || (pop && (issued_inc == count))) begin
                     drain_first <= 1'b1;
                     state       <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Core valids lag acceptance by an edge, so skip one idle sample.
               if (drain_first) begin
                  drain_first <= 1'b0;
               end else if (iCORE_IDLING) begin
                  oDONE <= 1'b1;
                  state <= FIN;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gppcu_instr_dispatcher.sv
// Directed bench for gppcu_instr_dispatcher with a sync-read memory model.
// Core ready/idle are driven per cycle relative to the accepted start.
module tb_gppcu_instr_dispatcher;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [9:0]  base;
   logic [10:0] icnt;
   logic        abort;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [9:0]  addr;
   logic        rd;
   logic [31:0] rdata;
   logic [31:0] instr;
   logic        valid;
   logic        ready;
   logic        idling;
   logic [10:0] issued;

   gppcu_instr_dispatcher dut (
      .iACLK       (clk),
      .inRST       (rst_n),
      .iSTART      (start),
      .iBASE_ADDR  (base),
      .iINSTR_COUNT(icnt),
      .iABORT      (abort),
      .oBUSY       (busy),
      .oDONE       (done),
      .oABORTED    (aborted),
      .oIMEM_ADDR  (addr),
      .oIMEM_RD    (rd),
      .iIMEM_RDATA (rdata),
      .oINSTR      (instr),
      .oINSTR_VALID(valid),
      .iINSTR_READY(ready),
      .iCORE_IDLING(idling),
      .oISSUED_CNT (issued)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [1024];
   always @(posedge clk) if (rd) rdata <= mem[addr];

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   int          cyc = 0;
   int          t0 = 0;
   logic [31:0] xfers [$];
   logic [9:0]  rdaddrs [$];
   int          done_cnt;
   int          done_k;
   logic        saw_done;
   logic        abort_at_done;
   logic [10:0] issued_at_done;
   int          stab_err;
   logic        held;
   logic [31:0] hold_val;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid && ready) xfers.push_back(instr);
         if (rd) rdaddrs.push_back(addr);
         if (held && valid && (instr != hold_val)) stab_err++;
         held     = valid && !ready;
         hold_val = instr;
         if (done) begin
            done_cnt++;
            done_k         = cyc - t0;
            saw_done       = 1'b1;
            abort_at_done  = aborted;
            issued_at_done = issued;
         end
      end
   end

   task automatic clear_logs();
      xfers.delete();
      rdaddrs.delete();
      done_cnt = 0;
      done_k   = -1;
      saw_done = 1'b0;
      stab_err = 0;
      held     = 1'b0;
   endtask

   // Cycle k counts from the edge that accepts start; pat bit i is ready at k=i+2.
   task automatic run(input logic [9:0] b, input logic [10:0] n,
                      input logic [15:0] pat, input int abort_k,
                      input logic abort_rdy, input int idle_k);
      int k;
      clear_logs();
      start = 1'b1;
      base  = b;
      icnt  = n;
      abort = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0    = cyc;
      k     = 0;
      while (k < 80 && !(saw_done && k > done_k + 1)) begin
         ready  = (k < 2 || k > 17) ? 1'b1 : pat[k-2];
         abort  = (k == abort_k);
         if (abort) ready = abort_rdy;
         idling = (k >= idle_k);
         if (abort_k >= 0 && k == abort_k + 1)
            check("abort_flush", {valid, rd}, 2'b00);
         @(posedge clk);
         #1;
         k++;
      end
      abort  = 1'b0;
      ready  = 1'b1;
      idling = 1'b1;
      check("done_seen", saw_done, 1'b1);
      check("done_width", done_cnt, 1);
      check("back_idle", busy, 1'b0);
   endtask

   task automatic check_words(input string tag, input logic [9:0] b,
                              input int n);
      logic [9:0]  a;
      logic [31:0] got;
      check({tag, "_nxfer"}, xfers.size(), n);
      for (int i = 0; i < n; i++) begin
         a   = b + 10'(i);
         got = (i < xfers.size()) ? xfers[i] : 32'hDEAD_BEEF;
         check({tag, "_word"}, got, 32'hC0DE_0000 + 32'(a));
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
      rst_n  = 1'b0;
      start  = 1'b0;
      base   = '0;
      icnt   = '0;
      abort  = 1'b0;
      ready  = 1'b1;
      idling = 1'b1;
      clear_logs();
      #1;
      check("reset_outs",
            {busy, done, aborted, addr, rd, instr, valid, issued}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: base 0x010, count 4, ready high
      run(10'h010, 11'd4, 16'hFFFF, -1, 1'b1, 0);
      check_words("t1", 10'h010, 4);
      check("t1_rdcnt", rdaddrs.size(), 4);
      check("t1_issued", issued, 11'd4);
      check("t1_done_k", done_k, 8);
      check("t1_abrt", abort_at_done, 1'b0);

      // 2: ready 1,0,0,1,0,1,1 and core busy until cycle 14
      run(10'h010, 11'd4, 16'hFFE9, -1, 1'b1, 14);
      check_words("t2", 10'h010, 4);
      check("t2_stable", stab_err, 0);
      check("t2_rdcnt", rdaddrs.size(), 4);
      check("t2_done_k", done_k, 15);
      check("t2_issued", issued_at_done, 11'd4);

      // 3: address wrap
      run(10'h3FE, 11'd4, 16'hFFFF, -1, 1'b1, 0);
      check("t3_nrd", rdaddrs.size(), 4);
      check("t3_a0", rdaddrs.size() > 0 ? rdaddrs[0] : 10'h155, 10'h3FE);
      check("t3_a1", rdaddrs.size() > 1 ? rdaddrs[1] : 10'h155, 10'h3FF);
      check("t3_a2", rdaddrs.size() > 2 ? rdaddrs[2] : 10'h155, 10'h000);
      check("t3_a3", rdaddrs.size() > 3 ? rdaddrs[3] : 10'h155, 10'h001);
      check_words("t3", 10'h3FE, 4);

      // 4: zero-length kernel
      run(10'h020, 11'd0, 16'hFFFF, -1, 1'b1, 0);
      check("t4_nrd", rdaddrs.size(), 0);
      check("t4_nxfer", xfers.size(), 0);
      check("t4_issued", issued, 11'd0);
      check("t4_done_k", done_k, 3);

      // 5: abort while head is stalled, after 3 transfers
      run(10'h040, 11'd8, 16'hFFF7, 5, 1'b0, 0);
      check_words("t5", 10'h040, 3);
      check("t5_issued", issued_at_done, 11'd3);
      check("t5_abrt", abort_at_done, 1'b1);
      check("t5_done_k", done_k, 8);
      check("t5_abrt_hold", aborted, 1'b1);

      // 5b: a transfer on the abort edge still counts
      run(10'h040, 11'd8, 16'hFFFF, 5, 1'b1, 0);
      check("t5b_issued", issued_at_done, 11'd4);
      check("t5b_abrt", abort_at_done, 1'b1);

      // 6: reset mid-run, then a clean run
      clear_logs();
      start = 1'b1;
      base  = 10'h000;
      icnt  = 11'd6;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t6_midrun", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_outs",
            {busy, done, aborted, addr, rd, instr, valid, issued}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run(10'h000, 11'd2, 16'hFFFF, -1, 1'b1, 0);
      check_words("t6", 10'h000, 2);
      check("t6_issued", issued, 11'd2);
      check("t6_abrt_clr", aborted, 1'b0);

      // start together with abort in IDLE is ignored
      clear_logs();
      start = 1'b1;
      abort = 1'b1;
      icnt  = 11'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", busy, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("sa_nrd", rdaddrs.size(), 0);
      check("sa_idle", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gppcu_instr_dispatcher.md
Name: gppcu_instr_dispatcher

Overview:
Sequences a kernel into the GPPCU core. On a start command it streams a contiguous block of instruction words from a synchronous-read instruction memory into the core's instruction valid/ready port. A 2-entry buffer absorbs the memory read latency and core back-pressure. When the last instruction has been accepted and the core reports idle, the block emits a one-cycle done pulse. It sits between the host control registers / instruction RAM and the core.

Parameters:
DBW, 32, instruction word width (matches core iINSTR)
IABW, 10, instruction memory address width
CBW, 11, instruction count width (IABW+1, allows full-memory kernels)

Ports:
iACLK  in  1  clock; all logic on rising edge
inRST  in  1  reset, asynchronous, active-low
iSTART  in  1  start pulse; sampled only in IDLE
iBASE_ADDR  in  IABW  first instruction address; latched on accepted start
iINSTR_COUNT  in  CBW  number of instructions to issue; latched on accepted start
iABORT  in  1  stop issuing, flush buffer, then drain
oBUSY  out  1  high in any state except IDLE
oDONE  out  1  one-cycle pulse when kernel complete or aborted and core idle
oABORTED  out  1  high with oDONE when the run ended by abort; held until next start
oIMEM_ADDR  out  IABW  instruction memory read address
oIMEM_RD  out  1  read strobe; data valid on iIMEM_RDATA exactly 1 cycle later
iIMEM_RDATA  in  DBW  instruction memory read data
oINSTR  out  DBW  instruction to core (core iINSTR)
oINSTR_VALID  out  1  to core iINSTR_VALID
iINSTR_READY  in  1  from core oINSTR_READY
iCORE_IDLING  in  1  from core oIDLING
oISSUED_CNT  out  CBW  instructions accepted by core in the current run

Behaviour:
- Reset (async, inRST=0): state IDLE; all outputs 0; buffer empty; counters 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - iSTART=1 and iABORT=0: latch base/count, clear oISSUED_CNT and oABORTED, go to RUN.
  - iSTART with iABORT same cycle: start ignored.
- RUN, read side:
  - Assert oIMEM_RD when reads remaining > 0 and (buffered + in-flight reads) < 2.
  - Address starts at base and increments by 1 per read, modulo 2^IABW (wrap from 2^IABW-1 to 0).
  - Returned word enters the buffer on the following cycle.
- RUN, issue side:
  - oINSTR/oINSTR_VALID present the buffer head.
  - Transfer occurs on a rising edge with VALID&READY=1: pop head, oISSUED_CNT+1.
  - Once VALID is asserted, oINSTR is held stable until transfer. Abort is the only exception.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Sustained throughput is 1 instr/cycle with READY held high. First VALID appears 2 cycles after start is accepted.
- RUN -> DRAIN: on the edge where the transfer makes oISSUED_CNT equal the latched count.
- Count 0: IDLE -> RUN -> DRAIN immediately; no reads issued.
- iABORT in RUN:
  - Next edge: oIMEM_RD=0, buffer flushed, oINSTR_VALID=0, discard any returning read data, set oABORTED, go to DRAIN.
  - A transfer on the abort edge itself still counts.
- DRAIN:
  - iCORE_IDLING is ignored in the first DRAIN cycle, because core pipeline valids lag acceptance by one edge.
  - Afterwards, go to DONE on the first cycle iCORE_IDLING=1.
  - iABORT in DRAIN has no effect.
- DONE: oDONE=1 for exactly one cycle, then IDLE. oISSUED_CNT and oABORTED hold until the next accepted start.
- iSTART while oBUSY=1 is ignored.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. The core is reset by the same inRST.

Test Plan:
1. Base=0x010, count=4, READY=1, memory holds A0..A3 → VALID high cycles 2..5 after start, with words A0,A1,A2,A3 in order. DONE pulses once, after core idling is seen from the 2nd DRAIN cycle on. oISSUED_CNT=4.
2. Same as 1, but READY toggles 1,0,0,1,0,1,1 → no word lost or duplicated; oINSTR stable while VALID&~READY; buffer never exceeds 2; oIMEM_RD deasserts when full.
3. Base=0x3FE, count=4 → read addresses 0x3FE,0x3FF,0x000,0x001.
4. Count=0 → no oIMEM_RD; oDONE pulses; oISSUED_CNT=0.
5. Count=8, READY=1, iABORT pulsed after 3 transfers → VALID drops next edge, late read data discarded, oISSUED_CNT=3, oABORTED=1 with oDONE.
6. inRST pulsed low mid-run with count=6 → all outputs 0 immediately; a subsequent start with base=0, count=2 runs cleanly. Also check iSTART+iABORT in the same IDLE cycle → stays IDLE.
